// File: rtl/edge_monitor_pkg.sv
// rtl/edge_monitor_pkg.sv - shared FSM encodings and default widths for edge_monitor
//   Contents: DEF_CNT_W, DEF_LEN_W, state_t (IDLE=0, HIGH=1, HOLD=2)
package edge_monitor_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/edge_monitor_sync.sv
// rtl/edge_monitor_sync.sv - input stage producing the sampled level s
//   Config macro: EDGE_MONITOR_SYNC_EN (two-flop synchronizer ahead of s)
//   Ports: clk, rst (async, active-high), sig_in (raw level), s (sampled level)
module edge_monitor_sync
    import edge_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s
);

`ifdef EDGE_MONITOR_SYNC_EN
    logic meta;
    logic sync;

    // Two metastability flops, then the s register: three edges from sig_in to s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            s    <= 1'b0;
        end else begin
            meta <= sig_in;
            sync <= meta;
            s    <= sync;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= 1'b0;
        end else begin
            s <= sig_in;
        end
    end
`endif

endmodule

// File: rtl/edge_monitor.sv
// rtl/edge_monitor.sv - edge detector, saturating rise counter and high-pulse length meter
//   Config macro: EDGE_MONITOR_SYNC_EN (selects input stage depth in edge_monitor_sync)
//   Ports: clk, rst (async, active-high), sig_in, clr (sync clear of rise_count/overrun)
//          rise_pulse, fall_pulse, rise_count[CNT_W]
//          evt_valid/evt_ready/evt_len[LEN_W] (measurement handshake), overrun (sticky drop flag)
module edge_monitor
    import edge_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [LEN_W-1:0] evt_len,
    output logic             overrun
);

    logic             s;
    logic             s_prev;
    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_nxt;
    logic [LEN_W-1:0] evt_len_nxt;
    logic             evt_valid_nxt;
    logic             drop;
    logic             handshake;

    edge_monitor_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .s      (s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s;
        end
    end

    // Both operands are flops, so the pulses are glitch-free one-cycle strobes.
    assign rise_pulse = s & ~s_prev;
    assign fall_pulse = ~s & s_prev;
    assign handshake  = evt_valid & evt_ready;

    // clr wins over a same-cycle increment or drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_count <= '0;
            overrun    <= 1'b0;
        end else if (clr) begin
            rise_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (rise_pulse && (rise_count != '1)) begin
                rise_count <= rise_count + CNT_W'(1);
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_cnt   <= '0;
            evt_len   <= '0;
            evt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_cnt   <= len_nxt;
            evt_len   <= evt_len_nxt;
            evt_valid <= evt_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        len_nxt       = len_cnt;
        evt_len_nxt   = evt_len;
        evt_valid_nxt = evt_valid;
        drop          = 1'b0;
        case (state)
            IDLE: begin
                // The rise cycle is itself the first high cycle.
                if (rise_pulse) begin
                    state_nxt = HIGH;
                    len_nxt   = LEN_W'(1);
                end
            end
            HIGH: begin
                if (fall_pulse) begin
                    state_nxt     = HOLD;
                    evt_len_nxt   = len_cnt;
                    evt_valid_nxt = 1'b1;
                end else if (len_cnt != '1) begin
                    len_nxt = len_cnt + LEN_W'(1);
                end
            end
            HOLD: begin
                if (handshake) begin
                    evt_valid_nxt = 1'b0;
                    if (rise_pulse) begin
                        // Slot frees up in the same cycle the new pulse starts.
                        state_nxt = HIGH;
                        len_nxt   = LEN_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (rise_pulse) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_edge_monitor.sv
// tb/tb_edge_monitor.sv - scoreboard bench for edge_monitor (honours EDGE_MONITOR_SYNC_EN)
module tb_edge_monitor;

    localparam int CNT_W = 8;
    localparam int LEN_W = 16;
`ifdef EDGE_MONITOR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic             clr = 1'b0;
    logic             evt_ready = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] rise_count;
    logic             evt_valid;
    logic [LEN_W-1:0] evt_len;
    logic             overrun;

    always #5 clk = ~clk;

    edge_monitor #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .clr        (clr),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .rise_count (rise_count),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_len    (evt_len),
        .overrun    (overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: s is sig_in seen LAT edges later; a high run is measured only
    // if no earlier result is still waiting (or it is being taken in the same cycle).
    bit m_s, m_sp, m_held, m_meas, m_ovr;
    int m_cnt, m_len;
    int exp_q[$];
    bit pipe[$];

    task automatic model_reset();
        m_s = 0; m_sp = 0; m_held = 0; m_meas = 0; m_ovr = 0;
        m_cnt = 0; m_len = 0;
        exp_q.delete();
        pipe.delete();
        for (int i = 0; i < LAT - 1; i++) pipe.push_back(1'b0);
    endtask

    task automatic model_step();
        bit rise, fall, hs, new_held, drop;
        rise = m_s && !m_sp;
        fall = !m_s && m_sp;
        hs = m_held && (evt_ready === 1'b1);
        new_held = m_held && !hs;
        drop = 0;
        if (m_meas) begin
            if (fall) begin
                exp_q.push_back(m_len);
                m_meas = 0;
                new_held = 1;
            end else if (m_len < LEN_MAX) begin
                m_len++;
            end
        end else if (rise) begin
            if (!m_held || hs) begin
                m_meas = 1;
                m_len = 1;
            end else begin
                drop = 1;
            end
        end
        if (clr) begin
            m_cnt = 0;
            m_ovr = 0;
        end else begin
            if (rise && m_cnt < CNT_MAX) m_cnt++;
            if (drop) m_ovr = 1;
        end
        m_held = new_held;
        pipe.push_back(sig_in);
        m_sp = m_s;
        m_s = pipe.pop_front();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Monitor: compares DUT against the model on the falling edge, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", {26'd0, rise_pulse, fall_pulse, evt_valid, overrun,
                                      |rise_count, |evt_len}, 32'd0);
            end else begin
                chk("mon_rise_pulse", {31'd0, rise_pulse}, {31'd0, m_s & ~m_sp});
                chk("mon_fall_pulse", {31'd0, fall_pulse}, {31'd0, ~m_s & m_sp});
                chk("mon_rise_count", 32'(rise_count), 32'(m_cnt));
                chk("mon_overrun", {31'd0, overrun}, {31'd0, m_ovr});
                chk("mon_evt_valid", {31'd0, evt_valid}, {31'd0, m_held});
                if (evt_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_evt", 32'(evt_len), 32'hFFFF_FFFF);
                    end else begin
                        chk("mon_evt_len", 32'(evt_len), 32'(exp_q[0]));
                        if (evt_ready === 1'b1) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    int n_rise, n_fall, last_len;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rise_pulse === 1'b1) n_rise++;
            if (fall_pulse === 1'b1) n_fall++;
            if (evt_valid === 1'b1) last_len = 32'(evt_len);
        end
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (rise_pulse !== 1'b1 && n < 10);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int run;
        cyc(3);
        chk("reset_rise_count", 32'(rise_count), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Single 20-cycle pulse with consumer always ready; also measures input latency.
        evt_ready = 1'b1;
        n_rise = 0; n_fall = 0; last_len = 0;
        sig_in = 1'b1;
        wait_rise(n);
        chk("rise_latency", 32'(n), 32'(LAT));
        cyc(20 - n);
        sig_in = 1'b0;
        cyc(LAT + 3);
        chk("p20_evt_len", 32'(last_len), 32'd20);
        chk("p20_rise_pulses", 32'(n_rise), 32'd1);
        chk("p20_fall_pulses", 32'(n_fall), 32'd1);
        chk("p20_rise_count", 32'(rise_count), 32'd1);

        // Consumer stalled: second pulse is dropped and flagged.
        evt_ready = 1'b0;
        pulse_clr();
        sig_in = 1'b1; cyc(5);
        sig_in = 1'b0; cyc(3);
        sig_in = 1'b1; cyc(3);
        sig_in = 1'b0; cyc(LAT + 3);
        chk("stall_evt_valid", {31'd0, evt_valid}, 32'd1);
        chk("stall_evt_len", 32'(evt_len), 32'd5);
        chk("stall_overrun", {31'd0, overrun}, 32'd1);
        chk("stall_rise_count", 32'(rise_count), 32'd2);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("stall_release_valid", {31'd0, evt_valid}, 32'd0);

        // Handshake and new rise in the same HOLD cycle.
        pulse_clr();
        sig_in = 1'b1; cyc(6);
        sig_in = 1'b0; cyc(LAT + 2);
        chk("hold_first_valid", {31'd0, evt_valid}, 32'd1);
        chk("hold_first_len", 32'(evt_len), 32'd6);
        sig_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            evt_ready = rise_pulse;
        end
        sig_in = 1'b0;
        evt_ready = 1'b0;
        cyc(LAT + 2);
        chk("hold_second_valid", {31'd0, evt_valid}, 32'd1);
        chk("hold_second_len", 32'(evt_len), 32'd4);
        chk("hold_overrun", {31'd0, overrun}, 32'd0);
        evt_ready = 1'b1;
        cyc(1);

        // 300 one-cycle pulses saturate the counter; clr beats a same-cycle rise.
        pulse_clr();
        for (int i = 0; i < 300; i++) begin
            sig_in = 1'b1; cyc(1);
            sig_in = 1'b0; cyc(1);
        end
        cyc(LAT + 2);
        chk("sat_rise_count", 32'(rise_count), 32'(CNT_MAX));
        sig_in = 1'b1;
        wait_rise(n);
        chk("clr_rise_seen", {31'd0, rise_pulse}, 32'd1);
        pulse_clr();
        chk("clr_rise_count", 32'(rise_count), 32'd0);
        sig_in = 1'b0;
        cyc(LAT + 3);

        // Reset in the middle of a measurement, input still high afterwards.
        evt_ready = 1'b0;
        sig_in = 1'b1;
        wait_rise(n);
        cyc(6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {26'd0, rise_pulse, fall_pulse, evt_valid, overrun,
                                    |rise_count, |evt_len}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(LAT + 2);
        chk("post_reset_rise_count", 32'(rise_count), 32'd1);
        chk("post_reset_valid", {31'd0, evt_valid}, 32'd0);
        sig_in = 1'b0;
        evt_ready = 1'b1;
        cyc(LAT + 3);

        // Randomized runs, random back-pressure and occasional clr.
        run = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                sig_in = ~sig_in;
                run = $urandom_range(1, 8);
            end
            run--;
            evt_ready = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 63) == 0);
            cyc(1);
        end
        clr = 1'b0;
        sig_in = 1'b0;
        evt_ready = 1'b1;
        cyc(LAT + 6);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_monitor.md
EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the rise-event counter.
REQ-002 SHALL have parameter LEN_W, default 16, width of the measured high-pulse length.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sig_in  input  1  monitored level (output B of the upstream hello stage).
REQ-006 SHALL have port clr  input  1  synchronous clear of rise_count and overrun.
REQ-007 SHALL have port rise_pulse  output  1  one-cycle pulse per detected rising edge.
REQ-008 SHALL have port fall_pulse  output  1  one-cycle pulse per detected falling edge.
REQ-009 SHALL have port rise_count  output  CNT_W  saturating count of rising edges.
REQ-010 SHALL have port evt_valid  output  1  completed pulse measurement available.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts measurement.
REQ-012 SHALL have port evt_len  output  LEN_W  high-pulse length in cycles, valid with evt_valid.
REQ-013 SHALL have port overrun  output  1  sticky, a pulse was dropped while a measurement was held.

Function
REQ-014 SHALL sample sig_in into internal level s through the input stage (REQ-030/031); s_prev SHALL be s delayed one cycle.
REQ-015 rise_pulse SHALL equal s & ~s_prev and fall_pulse ~s & s_prev, both driven from flops only.
REQ-016 rise_count SHALL increment by 1 on every cycle with rise_pulse, saturating at 2^CNT_W-1 (no wrap).
REQ-017 clr SHALL zero rise_count and overrun next edge; clr has priority over a same-cycle increment (that edge not counted); clr SHALL NOT affect FSM, evt_valid or evt_len.
REQ-018 FSM states SHALL be IDLE, HIGH, HOLD.
REQ-019 IDLE: on rise_pulse -> HIGH with length counter = 1.
REQ-020 HIGH: while s high, length counter +1 per cycle, saturating at 2^LEN_W-1; on fall_pulse -> HOLD, evt_len <= length counter, evt_valid <= 1.
REQ-021 HOLD: evt_valid and evt_len SHALL stay stable until evt_valid & evt_ready; on that handshake evt_valid <= 0 and -> IDLE.
REQ-022 HOLD with rise_pulse and no handshake: pulse SHALL be dropped (not measured), overrun <= 1, stay in HOLD.
REQ-023 HOLD with rise_pulse and handshake in the same cycle: handshake completes and -> HIGH with length counter = 1; overrun unchanged.
REQ-024 evt_ready while evt_valid low SHALL be ignored.
REQ-025 evt_len SHALL be the exact count of cycles s was high; latency from fall_pulse to evt_valid SHALL be 1 cycle.

Reset
REQ-026 rst SHALL asynchronously force FSM to IDLE and s, s_prev, sync flops, rise_pulse, fall_pulse, rise_count, evt_valid, evt_len, overrun, length counter to 0.
REQ-027 Reset mid-measurement (HIGH or HOLD) SHALL discard the measurement without any evt_valid.
REQ-028 If sig_in is high at reset release, the first sampled 1 SHALL be treated as a rising edge (counted and measured).
REQ-029 No output SHALL change on the first clock edge while rst is still asserted.

Configuration
REQ-030 With EDGE_MONITOR_SYNC_EN defined, sig_in SHALL pass a two-flop synchronizer before s: sig_in change to rise_pulse = 3 clk edges.
REQ-031 Without EDGE_MONITOR_SYNC_EN, s SHALL be sig_in registered once: sig_in change to rise_pulse = 1 clk edge; all other behaviour identical.

Structure
REQ-032 A shared package/include SHALL hold FSM state encodings (IDLE=2'd0, HIGH=2'd1, HOLD=2'd2) and default CNT_W/LEN_W constants.
REQ-033 Input stage SHALL be sub-module edge_monitor_sync (parameterised by macro); counters and FSM stay in edge_monitor.

Verification
REQ-034 sig_in 0 -> 1 for 20 cycles -> 0, evt_ready=1 -> one rise_pulse, one fall_pulse, evt_len=20, rise_count=1.
REQ-035 evt_ready=0, two pulses of 5 and 3 cycles -> evt_len=5 held, overrun=1, rise_count=2; then evt_ready=1 -> handshake, evt_valid=0.
REQ-036 300 one-cycle-spaced pulses, CNT_W=8 -> rise_count saturates at 255; clr with simultaneous rise -> rise_count=0.
REQ-037 rst asserted mid-HIGH (after 7 high cycles) -> all outputs 0 immediately, no evt_valid; sig_in still high after release -> rise_count=1.
REQ-038 HOLD with evt_ready and rise_pulse same cycle, next pulse 4 cycles -> first evt accepted, second evt_len=4, overrun=0.
REQ-039 Repeat REQ-034 with and without EDGE_MONITOR_SYNC_EN -> rise_pulse latency 3 vs 1 edges, identical evt_len.
